fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Core-side initiator for the FPU interface. It accepts one decoded FP instruction per handshake from the pipeline and drives the FPU request signals (f_LW, f_SW, f_wen, f_rs1/f_rs2/f_rd, frm_in, f_funct_7, dload_ext). It then holds the FPU operation until f_ready and returns store data and completion to the pipeline. It owns the architectural fflags/frm CSR state: exception flags accumulate sticky, and dynamic rounding mode is resolved from frm.

Parameters:
TIMEOUT_CYCLES, 64, maximum BUSY cycles before abort (used only with FPU_TIMEOUT_EN).

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  1  pipeline presents an FP instruction
req_ready  out  1  controller can accept an instruction
req_op  in  2  00 arith, 01 load (FLW), 10 store (FSW), 11 reserved
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_rd  in  5  destination register
req_rm  in  3  instruction rounding mode; 111 = dynamic
req_funct7  in  7  operation select
req_load_data  in  32  memory data for FLW
rsp_valid  out  1  one-cycle completion pulse
rsp_store_data  out  32  captured FPU_all_out for FSW
rsp_illegal  out  1  one-cycle pulse: request rejected
rsp_timeout  out  1  qualifies rsp_valid: op aborted
csr_fflags_we  in  1  CSR write to fflags
csr_fflags_wdata  in  5  fflags write data
csr_frm_we  in  1  CSR write to frm
csr_frm_wdata  in  3  frm write data
fcsr_fflags  out  5  sticky NV,DZ,OF,UF,NX
fcsr_frm  out  3  current dynamic rounding mode
f_LW  out  1  FPU load strobe
f_SW  out  1  FPU store strobe
f_wen  out  1  FPU register-file write enable
f_rs1  out  5  operand 1 select
f_rs2  out  5  operand 2 select
f_rd  out  5  destination select
frm_in  out  3  resolved rounding mode
f_funct_7  out  8  {1'b0, funct7}
dload_ext  out  32  load data to FPU
FPU_all_out  in  32  FPU store output
f_flags  in  5  FPU exception flags, valid with f_ready
f_frm_out  in  3  FPU frm echo, unused except in checks
f_ready  in  1  FPU operation complete

Behaviour:
- Reset: the reset is asynchronous and active-low (n_rst), with one clock (clk). On reset the state goes to IDLE and all outputs, fcsr_fflags and fcsr_frm go to 0. Reset mid-BUSY drops the op silently; no rsp_valid is produced.
- States: IDLE and BUSY.
- IDLE:
  - req_ready=1.
  - Acceptance happens on req_valid&&req_ready in cycle N.
  - Illegal request: req_op==11, or resolved rm in {101,110}, or req_rm==111 with fcsr_frm in {101,110,111}. The request is consumed, rsp_illegal=1 in N+1, and the state stays IDLE with no FPU strobes.
  - Legal request: latch all fields and go to BUSY. The FPU pins are driven from cycle N+1.
- BUSY:
  - req_ready=0.
  - Outputs held stable every cycle until completion.
  - frm_in = req_rm, or fcsr_frm as latched at acceptance if req_rm==111.
  - Arith: f_wen=1, f_LW=0, f_SW=0.
  - Load: f_LW=1, f_wen=1, dload_ext=latched req_load_data.
  - Store: f_SW=1, f_wen=0.
  - f_ready is sampled only in BUSY. f_ready in IDLE is ignored.
- Completion (f_ready=1 in BUSY, cycle M):
  - In M+1: rsp_valid=1, rsp_store_data=FPU_all_out (store only; otherwise it holds its previous value).
  - State returns to IDLE with all strobes 0.
  - Minimum latency from acceptance to rsp_valid is 2 cycles.
  - The next request can be accepted in M+1.
- fflags:
  - On arith completion, fflags |= f_flags.
  - Loads and stores never modify fflags.
  - If csr_fflags_we is in the same cycle as an arith completion, fflags = csr_fflags_wdata | f_flags.
  - A CSR write alone overwrites fflags.
- frm:
  - csr_frm_we overwrites frm at any time.
  - A dynamic op already in BUSY keeps its latched mode.
  - A CSR write in cycle N affects only requests accepted at N+1 or later.
- rsp_valid, rsp_illegal and rsp_timeout are one-cycle pulses and mutually exclusive in time.

Optional Feature:
FPU_TIMEOUT_EN:
- Defined: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on acceptance and increments each BUSY cycle without f_ready. When it reaches TIMEOUT_CYCLES, the op aborts. In the next cycle rsp_valid=1 and rsp_timeout=1, fflags are unchanged, and the state goes to IDLE. f_ready on the same cycle as the limit takes priority as a normal completion.
- Undefined: BUSY waits indefinitely and rsp_timeout is tied 0.

Test Plan:
1. Reset, then an arith op with rm=000, funct7=0x00, and f_ready after 3 cycles carrying f_flags=00001. Expect f_funct_7=0x00, f_wen=1, rsp_valid 1 cycle after f_ready, fcsr_fflags=00001.
2. Then a second op with f_flags=10000. Expect fcsr_fflags=10001 (sticky).
3. Set frm=011 by CSR write, then an op with req_rm=111. Expect frm_in=011. Write frm=001 during BUSY: frm_in stays 011.
4. FSW with FPU_all_out=0x3F800000 on f_ready. Expect f_SW=1, f_wen=0, rsp_store_data=0x3F800000, fflags unchanged. FLW with req_load_data=0x40490FDB: expect dload_ext=0x40490FDB, f_LW=1.
5. req_rm=101. Expect rsp_illegal pulse, no strobes, req_ready stays 1. Then frm=111 with req_rm=111: expect illegal.
6. Assert n_rst low mid-BUSY. Expect all outputs 0 asynchronously and no rsp_valid. With FPU_TIMEOUT_EN, TIMEOUT_CYCLES=8 and f_ready never asserted: expect rsp_valid&&rsp_timeout at cycle 9 after acceptance.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// Core-side FPU issue controller: accepts one FP instruction, drives the FPU pins until f_ready, owns fflags/frm.
// Optional macro FPU_TIMEOUT_EN aborts a BUSY op after TIMEOUT_CYCLES cycles without f_ready.
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic [2:0]  req_rm,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_load_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_store_data,
  output logic        rsp_illegal,
  output logic        rsp_timeout,
  input  logic        csr_fflags_we,
  input  logic [4:0]  csr_fflags_wdata,
  input  logic        csr_frm_we,
  input  logic [2:0]  csr_frm_wdata,
  output logic [4:0]  fcsr_fflags,
  output logic [2:0]  fcsr_frm,
  output logic        f_LW,
  output logic        f_SW,
  output logic        f_wen,
  output logic [4:0]  f_rs1,
  output logic [4:0]  f_rs2,
  output logic [4:0]  f_rd,
  output logic [2:0]  frm_in,
  output logic [7:0]  f_funct_7,
  output logic [31:0] dload_ext,
  input  logic [31:0] FPU_all_out,
  input  logic [4:0]  f_flags,
  input  logic [2:0]  f_frm_out,
  input  logic        f_ready
);

  localparam int unsigned OP_W   = 2;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned RM_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLG_W  = 5;

  localparam logic [OP_W-1:0] OP_ARITH = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD  = 2'b01;
  localparam logic [OP_W-1:0] OP_STORE = 2'b10;
  localparam logic [OP_W-1:0] OP_RSVD  = 2'b11;
  localparam logic [RM_W-1:0] RM_DYN   = 3'b111;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t              r_state;
  state_t              w_nxt_state;
  logic                w_accept;
  logic                w_illegal;
  logic                w_done;
  logic                w_abort;
  logic                w_bad;
  logic                w_to_hit;
  logic [RM_W-1:0]     w_rm_res;

  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_illegal;
  logic                r_rsp_timeout;
  logic [DATA_W-1:0]   r_rsp_store_data;
  logic [FLG_W-1:0]    r_fflags;
  logic [RM_W-1:0]     r_frm;
  logic [OP_W-1:0]     r_op;
  logic                r_f_LW;
  logic                r_f_SW;
  logic                r_f_wen;
  logic [REG_W-1:0]    r_f_rs1;
  logic [REG_W-1:0]    r_f_rs2;
  logic [REG_W-1:0]    r_f_rd;
  logic [RM_W-1:0]     r_frm_in;
  logic [7:0]          r_f_funct_7;
  logic [DATA_W-1:0]   r_dload_ext;

  // Dynamic rounding resolves from the CSR value as it stands in the acceptance cycle.
  assign w_rm_res = (req_rm == RM_DYN) ? r_frm : req_rm;
  assign w_bad    = (req_op == OP_RSVD) || (w_rm_res == 3'b101) ||
                    (w_rm_res == 3'b110) || (w_rm_res == 3'b111);

`ifdef FPU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_to_hit  = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Counts BUSY cycles without f_ready; the cycle that reaches the limit aborts.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == S_BUSY && !f_ready) begin
      r_cnt <= w_cnt_inc;
    end
  end
`else
  logic w_unused_to;
  assign w_to_hit    = 1'b0;
  assign w_unused_to = ^TIMEOUT_CYCLES;
`endif

  logic w_unused_frm;
  assign w_unused_frm = ^f_frm_out;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_accept    = 1'b0;
    w_illegal   = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          if (w_bad) begin
            w_illegal = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_nxt_state = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (f_ready) begin
          w_done      = 1'b1;
          w_nxt_state = S_IDLE;
        end else if (w_to_hit) begin
          w_abort     = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Response pulses and FPU pin registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_req_ready      <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_rsp_illegal    <= 1'b0;
      r_rsp_timeout    <= 1'b0;
      r_rsp_store_data <= '0;
      r_op             <= OP_ARITH;
      r_f_LW           <= 1'b0;
      r_f_SW           <= 1'b0;
      r_f_wen          <= 1'b0;
      r_f_rs1          <= '0;
      r_f_rs2          <= '0;
      r_f_rd           <= '0;
      r_frm_in         <= '0;
      r_f_funct_7      <= '0;
      r_dload_ext      <= '0;
    end else begin
      r_req_ready   <= (w_nxt_state == S_IDLE);
      r_rsp_valid   <= w_done || w_abort;
      r_rsp_illegal <= w_illegal;
      r_rsp_timeout <= w_abort;
      if (w_accept) begin
        r_op        <= req_op;
        r_f_LW      <= (req_op == OP_LOAD);
        r_f_SW      <= (req_op == OP_STORE);
        r_f_wen     <= (req_op != OP_STORE);
        r_f_rs1     <= req_rs1;
        r_f_rs2     <= req_rs2;
        r_f_rd      <= req_rd;
        r_frm_in    <= w_rm_res;
        r_f_funct_7 <= {1'b0, req_funct7};
        r_dload_ext <= (req_op == OP_LOAD) ? req_load_data : '0;
      end else if (w_done || w_abort) begin
        r_f_LW  <= 1'b0;
        r_f_SW  <= 1'b0;
        r_f_wen <= 1'b0;
      end
      if (w_done && r_op == OP_STORE) begin
        r_rsp_store_data <= FPU_all_out;
      end
    end
  end

  // CSR state: fflags sticky on arith completion, CSR write merges with same-cycle flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_fflags <= '0;
      r_frm    <= '0;
    end else begin
      if (csr_fflags_we) begin
        r_fflags <= csr_fflags_wdata | ((w_done && r_op == OP_ARITH) ? f_flags : '0);
      end else if (w_done && r_op == OP_ARITH) begin
        r_fflags <= r_fflags | f_flags;
      end
      if (csr_frm_we) begin
        r_frm <= csr_frm_wdata;
      end
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_illegal    = r_rsp_illegal;
  assign rsp_timeout    = r_rsp_timeout;
  assign rsp_store_data = r_rsp_store_data;
  assign fcsr_fflags    = r_fflags;
  assign fcsr_frm       = r_frm;
  assign f_LW           = r_f_LW;
  assign f_SW           = r_f_SW;
  assign f_wen          = r_f_wen;
  assign f_rs1          = r_f_rs1;
  assign f_rs2          = r_f_rs2;
  assign f_rd           = r_f_rd;
  assign frm_in         = r_frm_in;
  assign f_funct_7      = r_f_funct_7;
  assign dload_ext      = r_dload_ext;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl; the timeout case runs only with FPU_TIMEOUT_EN.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic [2:0]  req_rm;
  logic [6:0]  req_funct7;
  logic [31:0] req_load_data;
  logic        rsp_valid;
  logic [31:0] rsp_store_data;
  logic        rsp_illegal;
  logic        rsp_timeout;
  logic        csr_fflags_we;
  logic [4:0]  csr_fflags_wdata;
  logic        csr_frm_we;
  logic [2:0]  csr_frm_wdata;
  logic [4:0]  fcsr_fflags;
  logic [2:0]  fcsr_frm;
  logic        f_LW, f_SW, f_wen;
  logic [4:0]  f_rs1, f_rs2, f_rd;
  logic [2:0]  frm_in;
  logic [7:0]  f_funct_7;
  logic [31:0] dload_ext;
  logic [31:0] FPU_all_out;
  logic [4:0]  f_flags;
  logic [2:0]  f_frm_out;
  logic        f_ready;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_rm(req_rm),
    .req_funct7(req_funct7), .req_load_data(req_load_data),
    .rsp_valid(rsp_valid), .rsp_store_data(rsp_store_data),
    .rsp_illegal(rsp_illegal), .rsp_timeout(rsp_timeout),
    .csr_fflags_we(csr_fflags_we), .csr_fflags_wdata(csr_fflags_wdata),
    .csr_frm_we(csr_frm_we), .csr_frm_wdata(csr_frm_wdata),
    .fcsr_fflags(fcsr_fflags), .fcsr_frm(fcsr_frm),
    .f_LW(f_LW), .f_SW(f_SW), .f_wen(f_wen),
    .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd),
    .frm_in(frm_in), .f_funct_7(f_funct_7), .dload_ext(dload_ext),
    .FPU_all_out(FPU_all_out), .f_flags(f_flags), .f_frm_out(f_frm_out),
    .f_ready(f_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single acceptance edge; returns in cycle N+1.
  task automatic issue(input logic [1:0] op, input logic [2:0] rm, input logic [6:0] f7,
                       input logic [31:0] ld);
    req_valid = 1'b1; req_op = op; req_rm = rm; req_funct7 = f7; req_load_data = ld;
    req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd3;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits 'dly' BUSY cycles, then raises f_ready for one edge; returns in cycle M+1.
  task automatic complete(input int dly, input logic [4:0] flg, input logic [31:0] dout);
    for (int i = 0; i < dly; i++) begin
      chk("busy_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    f_ready = 1'b1; f_flags = flg; FPU_all_out = dout;
    tick();
    f_ready = 1'b0; f_flags = '0;
  endtask

  task automatic csr_frm(input logic [2:0] v);
    csr_frm_we = 1'b1; csr_frm_wdata = v;
    tick();
    csr_frm_we = 1'b0;
  endtask

  initial begin
    n_rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    req_rm = '0; req_funct7 = '0; req_load_data = '0;
    csr_fflags_we = 1'b0; csr_fflags_wdata = '0; csr_frm_we = 1'b0; csr_frm_wdata = '0;
    FPU_all_out = '0; f_flags = '0; f_frm_out = '0; f_ready = 1'b0;
    #1 n_rst = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_fflags", 32'(fcsr_fflags), 32'd0);
    chk("rst_frm", 32'(fcsr_frm), 32'd0);
    chk("rst_f_wen", 32'(f_wen), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // 1: arith rm=000, f_ready after 3 BUSY cycles, flags NX
    issue(2'b00, 3'b000, 7'h00, 32'h0);
    chk("a1_f_wen", 32'(f_wen), 32'd1);
    chk("a1_f_LW", 32'(f_LW), 32'd0);
    chk("a1_f_SW", 32'(f_SW), 32'd0);
    chk("a1_funct7", 32'(f_funct_7), 32'h00);
    chk("a1_frm_in", 32'(frm_in), 32'd0);
    chk("a1_f_rd", 32'(f_rd), 32'd3);
    chk("a1_req_ready", 32'(req_ready), 32'd0);
    complete(3, 5'b00001, 32'h0);
    chk("a1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("a1_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("a1_fflags", 32'(fcsr_fflags), 32'h01);
    chk("a1_strobe_off", 32'(f_wen), 32'd0);
    chk("a1_req_ready", 32'(req_ready), 32'd1);
    tick();
    chk("a1_pulse_end", 32'(rsp_valid), 32'd0);

    // 2: sticky accumulation, funct7 zero-extended
    issue(2'b00, 3'b001, 7'h7F, 32'h0);
    chk("a2_funct7", 32'(f_funct_7), 32'h7F);
    chk("a2_frm_in", 32'(frm_in), 32'd1);
    complete(1, 5'b10000, 32'h0);
    chk("a2_fflags", 32'(fcsr_fflags), 32'h11);

    // 3: dynamic rounding latched at acceptance
    csr_frm(3'b011);
    chk("frm_csr", 32'(fcsr_frm), 32'd3);
    issue(2'b00, 3'b111, 7'h01, 32'h0);
    chk("dyn_frm_in", 32'(frm_in), 32'd3);
    csr_frm(3'b001);
    chk("frm_csr_busy", 32'(fcsr_frm), 32'd1);
    chk("dyn_frm_held", 32'(frm_in), 32'd3);
    complete(0, 5'b00100, 32'h0);
    chk("a3_fflags", 32'(fcsr_fflags), 32'h15);

    // CSR write coinciding with arith completion, then CSR write alone
    issue(2'b00, 3'b000, 7'h02, 32'h0);
    csr_fflags_we = 1'b1; csr_fflags_wdata = 5'b00010;
    complete(0, 5'b01000, 32'h0);
    csr_fflags_we = 1'b0;
    chk("merge_fflags", 32'(fcsr_fflags), 32'h0A);
    csr_fflags_we = 1'b1; csr_fflags_wdata = 5'b00011;
    tick();
    csr_fflags_we = 1'b0;
    chk("csr_fflags_wr", 32'(fcsr_fflags), 32'h03);

    // 4: store then load; flags ignored for both
    issue(2'b10, 3'b000, 7'h00, 32'h0);
    chk("st_f_SW", 32'(f_SW), 32'd1);
    chk("st_f_wen", 32'(f_wen), 32'd0);
    chk("st_f_LW", 32'(f_LW), 32'd0);
    complete(2, 5'b11111, 32'h3F800000);
    chk("st_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("st_data", rsp_store_data, 32'h3F800000);
    chk("st_fflags", 32'(fcsr_fflags), 32'h03);
    issue(2'b01, 3'b000, 7'h00, 32'h40490FDB);
    chk("ld_dload", dload_ext, 32'h40490FDB);
    chk("ld_f_LW", 32'(f_LW), 32'd1);
    chk("ld_f_wen", 32'(f_wen), 32'd1);
    complete(0, 5'b11111, 32'hDEADBEEF);
    chk("ld_min_lat", 32'(rsp_valid), 32'd1);
    chk("ld_store_hold", rsp_store_data, 32'h3F800000);
    chk("ld_fflags", 32'(fcsr_fflags), 32'h03);

    // f_ready while IDLE has no effect
    f_ready = 1'b1;
    tick();
    f_ready = 1'b0;
    tick();
    chk("idle_fready", 32'(rsp_valid), 32'd0);

    // 5: illegal requests
    issue(2'b00, 3'b101, 7'h00, 32'h0);
    chk("ill_rm_pulse", 32'(rsp_illegal), 32'd1);
    chk("ill_rm_valid", 32'(rsp_valid), 32'd0);
    chk("ill_rm_wen", 32'(f_wen), 32'd0);
    chk("ill_rm_ready", 32'(req_ready), 32'd1);
    tick();
    chk("ill_pulse_end", 32'(rsp_illegal), 32'd0);
    issue(2'b11, 3'b000, 7'h00, 32'h0);
    chk("ill_op", 32'(rsp_illegal), 32'd1);
    csr_frm(3'b111);
    issue(2'b00, 3'b111, 7'h00, 32'h0);
    chk("ill_dyn", 32'(rsp_illegal), 32'd1);
    chk("ill_dyn_wen", 32'(f_wen), 32'd0);
    csr_frm(3'b000);

    // 6: asynchronous reset while BUSY
    issue(2'b00, 3'b000, 7'h05, 32'h0);
    chk("pre_rst_wen", 32'(f_wen), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_wen", 32'(f_wen), 32'd0);
    chk("arst_funct7", 32'(f_funct_7), 32'd0);
    chk("arst_fflags", 32'(fcsr_fflags), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    f_ready = 1'b1;
    tick();
    f_ready = 1'b0;
    n_rst = 1'b1;
    tick();
    chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
    chk("arst_idle", 32'(req_ready), 32'd1);

`ifdef FPU_TIMEOUT_EN
    csr_fflags_we = 1'b1; csr_fflags_wdata = 5'b00101;
    tick();
    csr_fflags_we = 1'b0;
    issue(2'b00, 3'b000, 7'h00, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      chk("to_wait", 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("to_valid", 32'(rsp_valid), 32'd1);
    chk("to_flag", 32'(rsp_timeout), 32'd1);
    chk("to_fflags", 32'(fcsr_fflags), 32'h05);
    chk("to_idle", 32'(req_ready), 32'd1);
    tick();
    chk("to_pulse_end", 32'(rsp_timeout), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
